// File: rtl/wir_ctrl.sv
// IEEE 1500 wrapper instruction register and serial control decoder.
// Drives the boundary-cell controls and selects the WSO source.
module wir_ctrl #(
  parameter int WIR_W = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wsi,
  input  logic             selectwir,
  input  logic             shiftwr,
  input  logic             capturewr,
  input  logic             updatewr,
  input  logic             wbr_so,
  output logic             wbr_si,
  output logic             shift,
  output logic             capture,
  output logic             update,
  output logic             mode,
  output logic             safe,
  output logic             io_face,
  output logic             wso,
  output logic [WIR_W-1:0] instr
);

  typedef enum logic [2:0] {
    OP_BYPASS  = 3'd0,
    OP_EXTEST  = 3'd1,
    OP_INTEST  = 3'd2,
    OP_SAFE    = 3'd3,
    OP_PRELOAD = 3'd4
  } op_e;

  // Unlisted codes fall back to bypass so the wrapper stays transparent.
  function automatic op_e decode_op(input logic [WIR_W-1:0] code);
    logic [31:0] c;
    c = 32'(code);
    case (c)
      32'd1:   return OP_EXTEST;
      32'd2:   return OP_INTEST;
      32'd3:   return OP_SAFE;
      32'd4:   return OP_PRELOAD;
      default: return OP_BYPASS;
    endcase
  endfunction

  logic [WIR_W-1:0] wir_sr_q, wir_sr_d;
  logic [WIR_W-1:0] wir_up_q, wir_up_d;
  logic             byp_q, byp_d;
  op_e              op;
  logic             data_sel;
  logic             boundary_op;

  assign op          = decode_op(wir_up_q);
  assign data_sel    = ~selectwir;
  assign boundary_op = (op != OP_BYPASS);

  always_comb begin
    wir_sr_d = wir_sr_q;
    wir_up_d = wir_up_q;
    byp_d    = byp_q;
    if (selectwir) begin
      if (capturewr) begin
        wir_sr_d = {{(WIR_W-1){1'b0}}, 1'b1};
      end else if (shiftwr) begin
        wir_sr_d = {wsi, wir_sr_q[WIR_W-1:1]};
      end
      // Update sees the pre-edge shift stage, independent of capture/shift.
      if (updatewr) begin
        wir_up_d = wir_sr_q;
      end
    end else if (!boundary_op) begin
      if (capturewr) begin
        byp_d = 1'b0;
      end else if (shiftwr) begin
        byp_d = wsi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wir_sr_q <= '0;
      wir_up_q <= '0;
      byp_q    <= 1'b0;
    end else begin
      wir_sr_q <= wir_sr_d;
      wir_up_q <= wir_up_d;
      byp_q    <= byp_d;
    end
  end

  always_comb begin
    shift   = data_sel & boundary_op & shiftwr & ~capturewr;
    capture = data_sel & ((op == OP_EXTEST) | (op == OP_INTEST)) & capturewr;
    update  = data_sel & boundary_op & updatewr;
    mode    = (op == OP_EXTEST) | (op == OP_INTEST);
    io_face = (op == OP_EXTEST);
    safe    = (op == OP_SAFE);
    if (selectwir) begin
      wso = wir_sr_q[0];
    end else if (!boundary_op) begin
      wso = byp_q;
    end else begin
      wso = wbr_so;
    end
  end

  assign wbr_si = wsi;
  assign instr  = wir_up_q;

endmodule
